switch_reader: RTL and testbench
================================

# switch_reader

Debounced input reader for up to `WIDTH` mechanical switches and push-buttons, the input-side counterpart of the LED output driver. It synchronises raw pad inputs into `clk`, filters contact bounce with per-bit counters, and publishes a stable switch vector. It also raises a sticky change event with a valid/ack handshake for the controller logic that selects servo modes and setpoints.

## Interface
- `WIDTH`, 8, number of switch inputs.
- `DEBOUNCE_CYCLES`, 50000, consecutive cycles a new level must persist before it is accepted (1 ms at 50 MHz); legal range ≥ 2.
- `SYNC_STAGES`, 2, synchroniser flop depth; legal range ≥ 2.

- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sw_in`  in  WIDTH  raw asynchronous switch levels.
- `sw_state`  out  WIDTH  debounced switch levels.
- `change_valid`  out  1  at least one bit of `sw_state` changed since the last acknowledge.
- `change_mask`  out  WIDTH  accumulated bits that flipped since the last acknowledge.
- `change_ack`  in  1  consumer acknowledge; acts only when `change_valid` = 1.
- `rise_latched`  out  WIDTH  sticky rising-edge flags; present only with `SWITCH_READER_RISE_CAPTURE_EN`.
- `rise_clear`  in  WIDTH  per-bit clear of `rise_latched`; present only with the macro.

## Operation
- Each bit passes through a `SYNC_STAGES`-deep flop chain. All further logic uses the last stage only.
- Each bit has an independent two-state FSM.
  - IDLE: sync = stable. Counter holds 0.
  - COUNT: sync ≠ stable. The counter increments each cycle.
  - COUNT→IDLE with counter cleared if sync returns to stable. Any single agreeing cycle restarts the filter.
  - When the counter is at `DEBOUNCE_CYCLES`-1 and sync still differs: stable ← sync, counter ← 0, return to IDLE, and emit a one-cycle internal `flip` pulse.
- Counter width is $clog2(`DEBOUNCE_CYCLES`). The counter never wraps, because it is cleared before reaching `DEBOUNCE_CYCLES`.
- `sw_state` is the vector of stable bits.
- Change event:
  - `change_mask` ← `change_mask` | flip. `change_valid` = 1 whenever the mask is non-zero (registered).
  - On an ack cycle (`change_ack` & `change_valid`): `change_mask` ← flip. Bits flipping in the same cycle are retained, not lost. `change_valid` remains 1 if that flip is non-zero.
  - `change_ack` while `change_valid` = 0 is ignored.
- A bit flipping twice before ack stays set in the mask. The consumer reads the level from `sw_state`.
- Reset values: synchroniser flops 0, `sw_state` 0, counters 0, all FSMs IDLE, `change_valid` 0, `change_mask` 0, `rise_latched` 0.
- Reset asserted mid-count abandons the count. No flip is reported for it.

## Timing
- Latency: a level on `sw_in` that is steady from rising edge E1 onward appears on `sw_state` at edge E1 + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1, i.e. the (`SYNC_STAGES` + `DEBOUNCE_CYCLES`)-th edge that samples it.
- `change_valid` and `change_mask` update on the same edge as `sw_state`.
- Acknowledge takes effect on the edge where `change_ack` is sampled high. Outputs clear on that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SWITCH_READER_RISE_CAPTURE_EN` defined:
  - Adds `rise_latched`/`rise_clear`.
  - Bit i sets on a flip where the new stable value is 1.
  - A clear and a set in the same cycle resolve to set.
- Macro undefined: those ports and registers do not exist. Remaining behaviour is identical.

## Structure
- Package `switch_reader_pkg`:
  - enum `db_state_t` {DB_IDLE, DB_COUNT}.
  - constants `SR_DEFAULT_WIDTH` = 8, `SR_DEFAULT_DEBOUNCE` = 50000, `SR_MIN_SYNC` = 2.
- Sub-module `debounce_bit`:
  - Contains one synchroniser, FSM and counter.
  - Outputs stable level and flip pulse.
  - Instantiated `WIDTH` times by generate loop.
- Top level holds the change-mask/handshake and optional rise-capture logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `SYNC_STAGES` = 2, `WIDTH` = 8.
- Reset: hold `reset_n` = 0 with `sw_in` = 8'hA5 → `sw_state` = 8'h00, `change_valid` = 0, `change_mask` = 8'h00 throughout.
- Clean step: `sw_in` 8'h00→8'hFF held → `sw_state` = 8'hFF exactly 6 edges after the first sampling edge, not 5. `change_valid` = 1 and `change_mask` = 8'hFF on that edge.
- Bounce: bit 0 toggles every 2 cycles for 20 cycles, then returns to 0 → `sw_state` stays 8'h00 and `change_valid` stays 0.
- Handshake:
  - After the step, pulse `change_ack` one cycle → next edge `change_valid` = 0, `change_mask` = 8'h00.
  - Repeat with bit 3 flipping on the ack edge → `change_valid` = 1, `change_mask` = 8'h08.
- Reset mid-operation: step bit 1 high, assert `reset_n` = 0 after 3 cycles, release → bit 1 needs a full 6 edges again, and no stale flip appears.
- Macro build: 8'h00→8'h81 → `rise_latched` = 8'h81. `rise_clear` = 8'h01 → 8'h80. Clear bit 7 on the cycle a new rise of bit 7 is reported → remains 8'h80.

Source files
------------

// File: rtl/switch_reader_pkg.sv
// ============================================================================
// Module      : switch_reader_pkg
// Description : Shared types and default constants for the debounced switch
//               reader and its per-bit debounce filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_reader_pkg;

  localparam int SR_DEFAULT_WIDTH    = 8;
  localparam int SR_DEFAULT_DEBOUNCE = 50000;
  localparam int SR_MIN_SYNC         = 2;

  // Per-bit filter state: IDLE while the synchronised level agrees with the
  // published level, COUNT while a differing level is being timed.
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

endpackage : switch_reader_pkg

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// Module      : debounce_bit
// Description : One switch input: synchroniser chain, two-state debounce FSM
//               and persistence counter. Publishes the accepted stable level
//               and a one-cycle flip pulse, asserted combinationally in the
//               cycle whose closing edge updates the stable level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit
  import switch_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_DEFAULT_DEBOUNCE,
  parameter int SYNC_STAGES     = SR_MIN_SYNC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic stable_o,
  output logic flip_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   flip_d;

  // Synchroniser chain: only the last stage feeds the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Filter state, counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DB_IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Next-state: the counter holds the number of consecutive differing samples
  // seen so far, so entering COUNT already accounts for the first one and the
  // DEBOUNCE_CYCLES-th differing sample commits the new level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_d   = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync_w != stable_q) begin
          state_d = DB_COUNT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      DB_COUNT: begin
        if (sync_w == stable_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DB_IDLE;
          cnt_d    = '0;
          stable_d = sync_w;
          flip_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable_o = stable_q;
  assign flip_o   = flip_d;

endmodule : debounce_bit

`default_nettype wire

// File: rtl/switch_reader.sv
// ============================================================================
// Module      : switch_reader
// Description : Debounced reader for WIDTH switches. Publishes the stable
//               switch vector plus a sticky change mask with a valid/ack
//               handshake. Optional sticky rising-edge capture is built when
//               the macro SWITCH_READER_RISE_CAPTURE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int WIDTH           = SR_DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = SR_DEFAULT_DEBOUNCE,
  parameter int SYNC_STAGES     = SR_MIN_SYNC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_state,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_mask,
`ifdef SWITCH_READER_RISE_CAPTURE_EN
  output logic [WIDTH-1:0] rise_latched,
  input  logic [WIDTH-1:0] rise_clear,
`endif
  input  logic             change_ack
);

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] flip_w;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             valid_q, valid_d;
  logic             ack_fire_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (reset_n),
      .sw_i    (sw_in[i]),
      .stable_o(stable_w[i]),
      .flip_o  (flip_w[i])
    );
  end

  assign ack_fire_w = change_ack & valid_q;

  // Accumulate flips; an acknowledge restarts the mask from this cycle's
  // flips so that a flip coinciding with the ack is not lost.
  always_comb begin
    mask_d  = ack_fire_w ? flip_w : (mask_q | flip_w);
    valid_d = |mask_d;
  end

  // Change-event registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  assign sw_state     = stable_w;
  assign change_mask  = mask_q;
  assign change_valid = valid_q;

`ifdef SWITCH_READER_RISE_CAPTURE_EN
  logic [WIDTH-1:0] rise_q, rise_d;

  // A flip with the old stable level at 0 is a rise; set beats clear.
  always_comb begin
    rise_d = (rise_q & ~rise_clear) | (flip_w & ~stable_w);
  end

  // Sticky rising-edge flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
    end else begin
      rise_q <= rise_d;
    end
  end

  assign rise_latched = rise_q;
`endif

endmodule : switch_reader

`default_nettype wire

// File: tb/tb_switch_reader.sv
// ============================================================================
// Module      : tb_switch_reader
// Description : Self-checking bench for switch_reader (WIDTH=8,
//               DEBOUNCE_CYCLES=4, SYNC_STAGES=2). Rise-capture checks are
//               included when SWITCH_READER_RISE_CAPTURE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_reader;

  localparam int W    = 8;
  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int HIST = SYNC + DEB;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic [W-1:0] sw_in      = '0;
  logic         change_ack = 1'b0;
  logic [W-1:0] sw_state;
  logic         change_valid;
  logic [W-1:0] change_mask;
`ifdef SWITCH_READER_RISE_CAPTURE_EN
  logic [W-1:0] rise_latched;
  logic [W-1:0] rise_clear = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [W-1:0] st;
    logic         v;
    logic [W-1:0] m;
    logic [W-1:0] r;
  } exp_t;

  exp_t exp_q[$];

  switch_reader #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_in       (sw_in),
    .sw_state    (sw_state),
    .change_valid(change_valid),
    .change_mask (change_mask),
`ifdef SWITCH_READER_RISE_CAPTURE_EN
    .rise_latched(rise_latched),
    .rise_clear  (rise_clear),
`endif
    .change_ack  (change_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DEB synchronised
  // samples (raw samples delayed by SYNC edges) all agree on a new value.
  logic [W-1:0] hist [HIST];
  logic [W-1:0] m_state, m_mask, m_rise;
  logic         m_valid;

  always @(posedge clk) begin : model
    logic [W-1:0] flip, all1, all0;
    exp_t e;
    if (!reset_n) begin
      for (int k = 0; k < HIST; k++) hist[k] = '0;
      m_state = '0; m_mask = '0; m_rise = '0; m_valid = 1'b0;
    end else begin
      for (int k = HIST - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw_in;
      all1 = '1;
      all0 = '1;
      for (int k = SYNC; k < HIST; k++) begin
        all1 = all1 & hist[k];
        all0 = all0 & ~hist[k];
      end
      flip = (all1 & ~m_state) | (all0 & m_state);
      if (change_ack && m_valid) m_mask = flip;
      else                       m_mask = m_mask | flip;
      m_state = m_state ^ flip;
`ifdef SWITCH_READER_RISE_CAPTURE_EN
      m_rise = (m_rise & ~rise_clear) | (flip & m_state);
`endif
      m_valid = (m_mask != '0);
    end
    e.st = m_state; e.v = m_valid; e.m = m_mask; e.r = m_rise;
    exp_q.push_back(e);
  end

  // Monitor: compares every registered output shortly after each edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty @%0t: got 0 entries, expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("mon_sw_state", sw_state, e.st);
      chk("mon_change_valid", W'(change_valid), W'(e.v));
      chk("mon_change_mask", change_mask, e.m);
`ifdef SWITCH_READER_RISE_CAPTURE_EN
      chk("mon_rise_latched", rise_latched, e.r);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : stimulus
    logic [2:0] bi;

    // Reset held with a non-zero input pattern.
    sw_in = 8'hA5;
    repeat (4) tick();
    chk("rst_sw_state", sw_state, 8'h00);
    chk("rst_valid", W'(change_valid), 8'h00);
    chk("rst_mask", change_mask, 8'h00);
    reset_n = 1'b1;
    sw_in   = 8'h00;
    repeat (8) tick();

    // Clean step: accepted on the 6th sampling edge, not the 5th.
    sw_in = 8'hFF;
    repeat (5) tick();
    chk("step_edge5_state", sw_state, 8'h00);
    tick();
    chk("step_edge6_state", sw_state, 8'hFF);
    chk("step_edge6_valid", W'(change_valid), 8'h01);
    chk("step_edge6_mask", change_mask, 8'hFF);

    // Plain acknowledge.
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    chk("ack_valid", W'(change_valid), 8'h00);
    chk("ack_mask", change_mask, 8'h00);

    // Acknowledge coinciding with a flip of bit 3.
    sw_in = 8'hFE;
    repeat (2) tick();
    sw_in = 8'hF6;
    repeat (4) tick();
    chk("pre_ack_mask", change_mask, 8'h01);
    tick();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    chk("ack_flip_valid", W'(change_valid), 8'h01);
    chk("ack_flip_mask", change_mask, 8'h08);
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;

    // Bounce on bit 0 from a clean zero state.
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    sw_in   = 8'h00;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      sw_in[0] = ~sw_in[0];
      repeat (2) tick();
    end
    sw_in[0] = 1'b0;
    repeat (8) tick();
    chk("bounce_state", sw_state, 8'h00);
    chk("bounce_valid", W'(change_valid), 8'h00);

    // Reset in the middle of a count on bit 1.
    sw_in = 8'h02;
    repeat (3) tick();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_mid_edge5_state", sw_state, 8'h00);
    chk("rst_mid_edge5_valid", W'(change_valid), 8'h00);
    tick();
    chk("rst_mid_edge6_state", sw_state, 8'h02);
    chk("rst_mid_edge6_mask", change_mask, 8'h02);

`ifdef SWITCH_READER_RISE_CAPTURE_EN
    // Rising-edge capture, clear, and set-beats-clear.
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    sw_in   = 8'h00;
    repeat (4) tick();
    sw_in = 8'h81;
    repeat (6) tick();
    chk("rise_set", rise_latched, 8'h81);
    rise_clear = 8'h01;
    tick();
    rise_clear = 8'h00;
    chk("rise_clear", rise_latched, 8'h80);
    sw_in = 8'h01;
    repeat (8) tick();
    sw_in = 8'h81;
    repeat (5) tick();
    rise_clear = 8'h80;
    tick();
    rise_clear = 8'h00;
    chk("rise_set_wins", rise_latched, 8'h80);
`endif

    // Randomised traffic with bursts, bounces, acks and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        sw_in = W'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        bi = 3'($urandom_range(0, 7));
        sw_in[bi] = ~sw_in[bi];
      end
      change_ack = ($urandom_range(0, 3) == 0);
`ifdef SWITCH_READER_RISE_CAPTURE_EN
      rise_clear = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
      tick();
    end
    change_ack = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_switch_reader

`default_nettype wire
